// File: rtl/subframe_plane_sequencer_pkg.sv
// Shared defaults and read-side state encoding for the subframe plane sequencer.
package subframe_pkg;
   localparam int DEF_CH           = 3;
   localparam int DEF_PLANES       = 19;
   localparam int DEF_CACHE_WIDTH  = 48;
   localparam int DEF_PIX_PER_LINE = 64;
   localparam int DEF_WORDS        = DEF_PIX_PER_LINE * DEF_CH / DEF_CACHE_WIDTH;
   localparam int DEF_WORD_AW      = $clog2(DEF_WORDS + 1);
   localparam int DEF_PLANE_W      = $clog2(DEF_PLANES);

   typedef enum logic [1:0] {
      RD_IDLE   = 2'd0,
      RD_LOAD   = 2'd1,
      RD_STREAM = 2'd2
   } rd_state_e;
endpackage

// File: rtl/subframe_plane_sequencer_packer.sv
// Packs CH bits per pixel of one bit-plane into CACHE_WIDTH words, first pixel at the LSBs.
module plane_word_packer
   import subframe_pkg::*;
#(
   parameter int CH          = DEF_CH,
   parameter int CACHE_WIDTH = DEF_CACHE_WIDTH
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   shift_en_i,
   input  logic [CH-1:0]          bits_i,
   input  logic                   flush_i,
   output logic [CACHE_WIDTH-1:0] word_o,
   output logic                   word_done_o
);
   localparam int PPW   = CACHE_WIDTH / CH;
   localparam int CNT_W = $clog2(PPW + 1);

   logic [CACHE_WIDTH-1:0] sr_q, sr_d;
   logic [CNT_W-1:0]       cnt_q;
   logic                   full;

   // The incoming pixel is merged combinationally so a completing or flushing word includes it.
   always_comb begin
      sr_d = sr_q;
      if (shift_en_i) sr_d[cnt_q*CH +: CH] = bits_i;
   end

   assign full        = shift_en_i && (cnt_q == CNT_W'(PPW - 1));
   assign word_done_o = full || (flush_i && (shift_en_i || cnt_q != '0));
   assign word_o      = sr_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sr_q  <= '0;
         cnt_q <= '0;
      end else if (full || flush_i) begin
         sr_q  <= '0;
         cnt_q <= '0;
      end else if (shift_en_i) begin
         sr_q  <= sr_d;
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end
endmodule

// File: rtl/subframe_plane_sequencer.sv
// Slices pixel codewords into bit-planes, buffers a line in ping-pong banks and
// streams the previous line plane-by-plane over valid/ready.
module subframe_plane_sequencer
   import subframe_pkg::*;
#(
   parameter int CH           = DEF_CH,
   parameter int PLANES       = DEF_PLANES,
   parameter int CACHE_WIDTH  = DEF_CACHE_WIDTH,
   parameter int PIX_PER_LINE = DEF_PIX_PER_LINE
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [CH*PLANES-1:0]        pix_code_i,
   input  logic                        pix_valid_i,
   input  logic                        line_end_i,
   input  logic                        msb_first_i,
   output logic [CACHE_WIDTH-1:0]      out_data_o,
   output logic                        out_valid_o,
   input  logic                        out_ready_i,
   output logic [$clog2(PLANES)-1:0]   out_plane_o,
   output logic                        out_last_o,
   output logic                        busy_o,
   output logic                        err_overrun_o,
   output logic                        err_overflow_o
);
   localparam int WORDS   = PIX_PER_LINE * CH / CACHE_WIDTH;
   localparam int WORD_AW = $clog2(WORDS + 1);
   localparam int WIX_W   = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam int PLANE_W = $clog2(PLANES);

   logic                               wr_bank_q;
   logic [WORD_AW-1:0]                 wr_word_q;
   logic [1:0][WORDS-1:0]              wvld_q;
   logic                               err_overflow_q, err_overrun_q;
   logic [PLANES-1:0][CH-1:0]          pk_bits;
   logic [PLANES-1:0][CACHE_WIDTH-1:0] pk_word, rd_word;
   logic [PLANES-1:0]                  pk_done;
   logic                               line_full, pix_acc, wr_en, swap, rd_en;
   logic [WIX_W-1:0]                   wr_ix;

   rd_state_e                          state_q;
   logic                               rd_bank_q, msb_q, out_valid_q, out_last_q, word_vld_q;
   logic [PLANE_W-1:0]                 ad_plane_q, out_plane_q, first_plane, last_plane, next_plane;
   logic [WIX_W-1:0]                   ad_word_q;
   logic                               ad_last;

   assign line_full = (wr_word_q == WORD_AW'(WORDS));
   assign pix_acc   = pix_valid_i && !line_full;
   assign wr_en     = |pk_done;
   assign wr_ix     = wr_word_q[WIX_W-1:0];
   assign swap      = line_end_i && (state_q == RD_IDLE);
   assign rd_en     = (state_q == RD_LOAD) || (state_q == RD_STREAM && out_ready_i && !out_last_q);

   for (genvar p = 0; p < PLANES; p++) begin : g_plane
      for (genvar c = 0; c < CH; c++) begin : g_ch
         assign pk_bits[p][c] = pix_code_i[c*PLANES + p];
      end

      plane_word_packer #(.CH(CH), .CACHE_WIDTH(CACHE_WIDTH)) u_pk (
         .clk        (clk),
         .rst_n      (rst_n),
         .shift_en_i (pix_acc),
         .bits_i     (pk_bits[p]),
         .flush_i    (line_end_i),
         .word_o     (pk_word[p]),
         .word_done_o(pk_done[p])
      );

      logic [CACHE_WIDTH-1:0] mem [2**(WIX_W+1)];
      logic [CACHE_WIDTH-1:0] rd_q;
      always_ff @(posedge clk) begin
         if (wr_en) mem[{wr_bank_q, wr_ix}] <= pk_word[p];
         if (rd_en) rd_q <= mem[{rd_bank_q, ad_word_q}];
      end
      assign rd_word[p] = rd_q;
   end

   // Per-word valid bits give a zero-cost clear of the bank that starts a new line.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_bank_q      <= 1'b0;
         wr_word_q      <= '0;
         wvld_q         <= '0;
         err_overflow_q <= 1'b0;
      end else begin
         if (wr_en) begin
            wr_word_q            <= wr_word_q + WORD_AW'(1);
            wvld_q[wr_bank_q][wr_ix] <= 1'b1;
         end
         if (line_end_i) begin
            wr_word_q                    <= '0;
            wvld_q[wr_bank_q ^ swap]     <= '0;
         end
         if (swap) wr_bank_q <= ~wr_bank_q;
         if (pix_valid_i && line_full) err_overflow_q <= 1'b1;
      end
   end

   assign first_plane = msb_first_i ? PLANE_W'(PLANES - 1) : '0;
   assign last_plane  = msb_q ? '0 : PLANE_W'(PLANES - 1);
   assign next_plane  = msb_q ? ad_plane_q - PLANE_W'(1) : ad_plane_q + PLANE_W'(1);
   assign ad_last     = (ad_plane_q == last_plane) && (ad_word_q == WIX_W'(WORDS - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= RD_IDLE;
         rd_bank_q     <= 1'b0;
         msb_q         <= 1'b0;
         ad_plane_q    <= '0;
         ad_word_q     <= '0;
         out_plane_q   <= '0;
         out_valid_q   <= 1'b0;
         out_last_q    <= 1'b0;
         word_vld_q    <= 1'b0;
         err_overrun_q <= 1'b0;
      end else begin
         if (line_end_i && state_q != RD_IDLE) err_overrun_q <= 1'b1;
         case (state_q)
            RD_IDLE: if (line_end_i) begin
               state_q    <= RD_LOAD;
               rd_bank_q  <= wr_bank_q;
               msb_q      <= msb_first_i;
               ad_plane_q <= first_plane;
               ad_word_q  <= '0;
            end
            RD_LOAD: begin
               state_q     <= RD_STREAM;
               out_valid_q <= 1'b1;
            end
            RD_STREAM: if (out_ready_i && out_last_q) begin
               state_q     <= RD_IDLE;
               out_valid_q <= 1'b0;
               out_last_q  <= 1'b0;
            end
            default: state_q <= RD_IDLE;
         endcase
         // Capture the word being read and advance the address, no bubble at plane boundaries.
         if (rd_en) begin
            out_plane_q <= ad_plane_q;
            out_last_q  <= ad_last;
            word_vld_q  <= wvld_q[rd_bank_q][ad_word_q];
            if (ad_word_q == WIX_W'(WORDS - 1)) begin
               ad_word_q  <= '0;
               ad_plane_q <= next_plane;
            end else begin
               ad_word_q <= ad_word_q + WIX_W'(1);
            end
         end
      end
   end

   assign out_data_o     = (out_valid_q && word_vld_q) ? rd_word[out_plane_q] : '0;
   assign out_valid_o    = out_valid_q;
   assign out_plane_o    = out_plane_q;
   assign out_last_o     = out_last_q;
   assign busy_o         = (state_q != RD_IDLE);
   assign err_overrun_o  = err_overrun_q;
   assign err_overflow_o = err_overflow_q;
endmodule
